// File: rtl/dram_fifo_ctrl.sv
// dram_fifo_ctrl
//   Single-clock FIFO controller placed in front of a dual-port RAM with a
//   1-cycle registered read port. It converts push/pop requests into RAM write
//   commands (port A) and read commands (port B). It returns popped words with
//   a valid strobe aligned to the RAM read. It also provides occupancy,
//   full/empty and almost flags, and sticky overflow/underflow errors.
//
//   Ports
//     clk_i, rst_i              clock, synchronous active-high reset
//     push_i, push_data_i       write request and data
//     pop_i                     read request
//     pop_data_o, pop_valid_o   read data and its valid strobe
//     full_o, afull_o           full and almost-full flags
//     empty_o, aempty_o         empty and almost-empty flags
//     count_o                   occupancy, 0..DEPTH
//     ovf_o, udf_o, clr_err_i   sticky errors and their clear
//     ram_wr_*                  RAM port A write command
//     ram_rd_*, ram_rd_data_i   RAM port B read command and returned data
module dram_fifo_ctrl #(
  parameter int DLY       = 1,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AW        = $clog2(DEPTH),
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  output logic             afull_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             pop_valid_o,
  output logic             empty_o,
  output logic             aempty_o,
  output logic [AW:0]      count_o,
  output logic             ovf_o,
  output logic             udf_o,
  input  logic             clr_err_i,
  output logic             ram_wr_en_o,
  output logic [AW-1:0]    ram_wr_addr_o,
  output logic [WIDTH-1:0] ram_wr_data_o,
  output logic             ram_rd_en_o,
  output logic [AW-1:0]    ram_rd_addr_o,
  input  logic [WIDTH-1:0] ram_rd_data_i
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AEMPTY_TH);

  // Registers are modelled with zero delay. DLY is kept only so that
  // instantiations which set it still elaborate.
  logic dly_unused;
  assign dly_unused = (DLY != 0);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_valid_q, pop_valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;

  // The flags decode the registered count only, so they never depend on the
  // same-cycle requests.
  assign full_o   = (count_q == FULL_CNT);
  assign empty_o  = (count_q == '0);
  assign afull_o  = (count_q >= AF_CNT);
  assign aempty_o = (count_q <= AE_CNT);
  assign count_o  = count_q;

  // Reset masks both accepts, so no RAM command escapes during reset.
  assign wr_acc = push_i & ~full_o & ~rst_i;
  assign rd_acc = pop_i & ~empty_o & ~rst_i;

  assign ram_wr_en_o   = wr_acc;
  assign ram_rd_en_o   = rd_acc;
  assign ram_wr_addr_o = rst_i ? '0 : wr_ptr_q;
  assign ram_rd_addr_o = rst_i ? '0 : rd_ptr_q;
  assign ram_wr_data_o = rst_i ? '0 : push_data_i;

  // The RAM registers its read word on the same edge that registers
  // pop_valid, so the data passes straight through.
  assign pop_data_o  = ram_rd_data_i;
  assign pop_valid_o = pop_valid_q;
  assign ovf_o       = ovf_q;
  assign udf_o       = udf_q;

  always_comb begin
    // DEPTH is a power of two, so the AW-bit pointers wrap by natural overflow.
    wr_ptr_d    = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d    = rd_ptr_q + AW'(rd_acc);
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    pop_valid_d = rd_acc;
    // A new error in the same cycle as the clear takes priority.
    ovf_d       = (ovf_q & ~clr_err_i) | (push_i & full_o);
    udf_d       = (udf_q & ~clr_err_i) | (pop_i & empty_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

endmodule

// File: tb/tb_dram_fifo_ctrl.sv
module tb_dram_fifo_ctrl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk_i = 1'b0;
  logic             rst_i, push_i, pop_i, clr_err_i;
  logic [WIDTH-1:0] push_data_i;
  logic             full_o, afull_o, empty_o, aempty_o, pop_valid_o, ovf_o, udf_o;
  logic [WIDTH-1:0] pop_data_o;
  logic [AW:0]      count_o;
  logic             ram_wr_en_o, ram_rd_en_o;
  logic [AW-1:0]    ram_wr_addr_o, ram_rd_addr_o;
  logic [WIDTH-1:0] ram_wr_data_o;
  logic [WIDTH-1:0] ram_rd_data_i = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  dram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .push_i(push_i), .push_data_i(push_data_i), .full_o(full_o), .afull_o(afull_o),
    .pop_i(pop_i), .pop_data_o(pop_data_o), .pop_valid_o(pop_valid_o),
    .empty_o(empty_o), .aempty_o(aempty_o), .count_o(count_o),
    .ovf_o(ovf_o), .udf_o(udf_o), .clr_err_i(clr_err_i),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i)
  );

  // Behavioural dual-port RAM with a registered read port.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk_i) begin
    if (ram_wr_en_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
    if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst, push, pop, clr;
    logic [15:0] data;
    logic        wen;  logic [2:0] waddr;
    logic        ren;  logic [2:0] raddr;
    int          cnt;
    logic        vld;  logic [15:0] pdata;
    logic        ovf, udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, push, pop, clr, input logic [15:0] data,
                     input logic wen, input logic [2:0] waddr,
                     input logic ren, input logic [2:0] raddr,
                     input int cnt, input logic vld, input logic [15:0] pdata,
                     input logic ovf, udf);
    vec_t v;
    v.rst = rst; v.push = push; v.pop = pop; v.clr = clr; v.data = data;
    v.wen = wen; v.waddr = waddr; v.ren = ren; v.raddr = raddr;
    v.cnt = cnt; v.vld = vld; v.pdata = pdata; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flags expected from an occupancy value (DEPTH=8, AFULL_TH=6, AEMPTY_TH=2).
  task automatic chk_cnt(input string tag, input int cnt);
    chk({tag, " count"}, int'(count_o), cnt);
    chk({tag, " full"}, int'(full_o), int'(cnt == 8));
    chk({tag, " empty"}, int'(empty_o), int'(cnt == 0));
    chk({tag, " afull"}, int'(afull_o), int'(cnt >= 6));
    chk({tag, " aempty"}, int'(aempty_o), int'(cnt <= 2));
  endtask

  task automatic drive(input logic rst, push, pop, clr, input logic [15:0] data);
    @(negedge clk_i);
    rst_i = rst; push_i = push; pop_i = pop; clr_err_i = clr; push_data_i = data;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input logic push, pop, input logic [15:0] data);
    drive(1'b0, push, pop, 1'b0, data);
    tick();
  endtask

  task automatic chk_pop(input string tag, input logic vld, input logic [15:0] d);
    chk({tag, " pop_valid"}, int'(pop_valid_o), int'(vld));
    if (vld) chk({tag, " pop_data"}, int'(pop_data_o), int'(d));
  endtask

  initial begin
    rst_i = 1'b1; push_i = 1'b0; pop_i = 1'b0; clr_err_i = 1'b0; push_data_i = '0;

    //   rst push pop clr data   wen wa ren ra cnt vld pdata ovf udf
    add(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    add(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 0, 0, 16'(k), 1, 3'(k-1), 0, 0, k, 0, 16'h0, 0, 0);
    // Push while full: rejected, pointer stays at 0 (wrapped), overflow sets.
    add(0, 1, 0, 0, 16'h9, 0, 0, 0, 0, 8, 0, 16'h0, 1, 0);
    for (int j = 0; j < 8; j++)
      add(0, 0, 1, 0, 16'h0, 0, 0, 1, 3'(j), 7-j, 1, 16'(j+1), 1, 0);
    // Pop while empty: rejected, underflow sets.
    add(0, 0, 1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 1);
    add(0, 0, 0, 1, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    // Error in the same cycle as clear: set wins.
    add(0, 0, 1, 1, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 1);
    add(0, 0, 0, 1, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].data);
      chk({tag, " ram_wr_en"}, int'(ram_wr_en_o), int'(vecs[i].wen));
      chk({tag, " ram_wr_addr"}, int'(ram_wr_addr_o), int'(vecs[i].waddr));
      chk({tag, " ram_wr_data"}, int'(ram_wr_data_o), vecs[i].rst ? 0 : int'(vecs[i].data));
      chk({tag, " ram_rd_en"}, int'(ram_rd_en_o), int'(vecs[i].ren));
      chk({tag, " ram_rd_addr"}, int'(ram_rd_addr_o), int'(vecs[i].raddr));
      tick();
      chk_cnt(tag, vecs[i].cnt);
      chk_pop(tag, vecs[i].vld, vecs[i].pdata);
      chk({tag, " ovf"}, int'(ovf_o), int'(vecs[i].ovf));
      chk({tag, " udf"}, int'(udf_o), int'(vecs[i].udf));
    end

    // Steady state at count 3: push and pop every cycle, pointers wrap.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 16'(16'h10 + k));
    chk_cnt("ss_fill", 3);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b1, 16'(16'h13 + k));
      chk_cnt($sformatf("ss%0d", k), 3);
      chk_pop($sformatf("ss%0d", k), 1'b1, 16'(16'h10 + k));
    end

    // Full plus push plus pop: pop taken, push refused and flagged.
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 16'(16'h27 + k));
    chk_cnt("full_fill", 8);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h2c);
    chk("full_pp ram_wr_en", int'(ram_wr_en_o), 0);
    chk("full_pp ram_rd_en", int'(ram_rd_en_o), 1);
    tick();
    chk_cnt("full_pp", 7);
    chk_pop("full_pp", 1'b1, 16'h24);
    chk("full_pp ovf", int'(ovf_o), 1);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 1'b1, 16'h0);
      chk_pop($sformatf("drain%0d", k), 1'b1, (k < 2) ? 16'(16'h25 + k) : 16'(16'h27 + k - 2));
    end
    chk_cnt("drained", 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    tick();
    chk("clr ovf", int'(ovf_o), 0);

    // Empty plus push plus pop: push taken, pop refused and flagged.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h30);
    chk("empty_pp ram_wr_en", int'(ram_wr_en_o), 1);
    chk("empty_pp ram_rd_en", int'(ram_rd_en_o), 0);
    tick();
    chk_cnt("empty_pp", 1);
    chk_pop("empty_pp", 1'b0, 16'h0);
    chk("empty_pp udf", int'(udf_o), 1);
    cyc(1'b0, 1'b0, 16'h0);
    chk_pop("empty_pp+1", 1'b0, 16'h0);

    // Reset on the same edge as an accepted pop at count 5.
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 16'(16'h31 + k));
    chk_cnt("pre_rst", 5);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'hbeef);
    chk("rst ram_rd_en", int'(ram_rd_en_o), 0);
    chk("rst ram_wr_en", int'(ram_wr_en_o), 0);
    chk("rst ram_wr_data", int'(ram_wr_data_o), 0);
    tick();
    chk_cnt("post_rst", 0);
    chk("post_rst pop_valid", int'(pop_valid_o), 0);
    chk("post_rst udf", int'(udf_o), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    tick();
    chk("idle pop_valid", int'(pop_valid_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
